// File: rtl/prog_loader.sv
// Streams per-core instruction images from a byte channel into the
// programming write port, one little-endian word per write.
module prog_loader #(
   parameter int CORES       = 8,
   parameter int LOG_CORES   = 3,
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   we,
   output logic [LOG_CORES-1:0]   sel,
   output logic [PC_WIDTH-1:0]    waddr,
   output logic [INSTR_WIDTH-1:0] wdata
);

   localparam int BYTES = INSTR_WIDTH / 8;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [2:0] {
      IDLE, COUNT, DATA, WRITE, DONE
   } state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic [BW-1:0] bidx;
   logic          last_core;
   logic          last_byte;

   assign last_core = (sel == LOG_CORES'(CORES - 1));
   assign last_byte = (bidx == BW'(BYTES - 1));

   // Control outputs are pure decodes of the state register.
   assign busy     = (state != IDLE);
   assign in_ready = (state == COUNT) || (state == DATA);
   assign we       = (state == WRITE);
   assign done     = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
         waddr <= '0;
         wdata <= '0;
         cnt   <= '0;
         bidx  <= '0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= COUNT;
                  sel   <= '0;
                  waddr <= '0;
               end
            end
            COUNT: begin
               if (in_valid) begin
                  if (in_data == 8'd0) begin
                     if (last_core) state <= DONE;
                     else           sel   <= sel + 1'b1;
                  end else begin
                     cnt   <= in_data;
                     waddr <= '0;
                     bidx  <= '0;
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (in_valid) begin
                  wdata[{bidx, 3'b000} +: 8] <= in_data;
                  if (last_byte) state <= WRITE;
                  else           bidx  <= bidx + 1'b1;
               end
            end
            WRITE: begin
               waddr <= waddr + 1'b1;
               cnt   <= cnt - 1'b1;
               bidx  <= '0;
               if (cnt == 8'd1) begin
                  if (last_core) begin
                     state <= DONE;
                  end else begin
                     sel   <= sel + 1'b1;
                     state <= COUNT;
                  end
               end else begin
                  state <= DATA;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameters: CORES, default 8, number of cores; LOG_CORES, default 3, core-select width; PC_WIDTH, default 8, program address width (fixed at 8); INSTR_WIDTH, default 32, instruction width (multiple of 8).
REQ-002 SHALL have ports: clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start  in  1  single-cycle pulse that begins a load session.
REQ-005 SHALL have ports: abort  in  1  terminates the session and returns to IDLE.
REQ-006 SHALL have ports: in_valid  in  1, in_data  in  8, in_ready  out  1  byte stream; a byte transfers in a cycle where in_valid and in_ready are both 1.
REQ-007 SHALL have ports: busy  out  1, high in any state other than IDLE.
REQ-008 SHALL have ports: done  out  1, a one-cycle pulse at the end of a session.
REQ-009 SHALL have ports: we  out  1, sel  out  LOG_CORES, waddr  out  PC_WIDTH, wdata  out  INSTR_WIDTH  programming write port, which drives the programming multiplexer.

Function
REQ-010 SHALL be driven from a registered FSM with states IDLE, COUNT, DATA, WRITE and DONE.
REQ-011 SHALL, in IDLE, ignore the stream (in_ready=0), and on start enter COUNT with sel=0.
REQ-012 SHALL ignore start in every state other than IDLE.
REQ-013 SHALL, in COUNT, drive in_ready=1; each accepted byte is the word count N for core sel.
REQ-014 SHALL, on N=0 in COUNT, skip the core: if sel<CORES-1 then sel+1 and stay in COUNT; otherwise go to DONE.
REQ-015 SHALL, on N>0 in COUNT, load the remaining-word counter with N, clear waddr and the byte index, and enter DATA.
REQ-016 SHALL, in DATA, drive in_ready=1 and place byte k of each word into wdata[8k+7:8k], so the word is assembled little-endian in INSTR_WIDTH/8 bytes.
REQ-017 SHALL enter WRITE on acceptance of the last byte of a word.
REQ-018 SHALL, in WRITE, drive in_ready=0 and we=1 for exactly one cycle with the current sel, waddr and the fully assembled wdata.
REQ-019 SHALL therefore assert we the cycle after the last byte handshake.
REQ-020 SHALL, after WRITE, increment waddr and decrement the counter. If the counter becomes 0, advance to the next core in COUNT, or go to DONE after core CORES-1. Otherwise return to DATA with byte index 0.
REQ-021 SHALL wrap waddr modulo 2^PC_WIDTH; N is at most 255, so no wrap occurs within one core.
REQ-022 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE with busy=0.
REQ-023 SHALL tolerate in_valid gaps anywhere: stalls do not change state, and a partial word is held.
REQ-024 SHALL give abort priority over start and over all stream activity; any state goes to IDLE on the next edge, with no we and no done.
REQ-025 SHALL complete the pending WRITE in full when abort arrives during WRITE, so that we does not glitch; the return to IDLE follows on the next edge.
REQ-026 SHALL drive we only from the WRITE state, and it SHALL be a registered-state decode.
REQ-027 SHALL drive waddr, wdata and sel directly from registers.

Reset
REQ-028 SHALL, while rst is high, force state IDLE and all outputs and registers to 0: we, done, busy, in_ready, sel, waddr, wdata, counter and byte index.
REQ-029 SHALL treat a reset mid-session as a full abort; a partially assembled word is discarded and no we is issued.

Verification
REQ-030 SHALL pass this case: start, then bytes 01, 78,56,34,12, then 00 x7 -> one we with sel=0, waddr=0, wdata=0x12345678 in the cycle after byte 0x12; done follows 7 COUNT bytes later; busy=0 afterwards.
REQ-031 SHALL pass this case: start, with every core given N=2 and distinct words -> 16 we pulses, with waddr 0,1 per core and sel 0..7 in order, then a single done.
REQ-032 SHALL pass this case: in_valid toggled randomly (about 50%) during the REQ-030 stream -> identical we/sel/waddr/wdata sequence, and in_ready=0 during WRITE.
REQ-033 SHALL pass this case: abort after 2 data bytes of a word -> no we and no done; next cycle busy=0. A new start restarts at sel=0, waddr=0.
REQ-034 SHALL pass this case: rst asserted asynchronously mid-DATA -> outputs 0 immediately, before the next edge; after release, start is required before in_ready rises.
REQ-035 SHALL pass this case: start pulsed while busy -> no effect on sel, waddr or the counter.
